// File: rtl/rb_subtract_8.sv
// rb_subtract_8: 8-bit unsigned ripple-borrow subtractor with a registered
// output stage. D = (A - B - Bin) mod 256 and Bout = borrow out of bit 7.
// The result is captured one clock after an accepted (in_valid) input.
// The borrow ripples through eight full-subtractor cells on purpose; no
// arithmetic operators are used, so the netlist keeps the ripple topology.

// Half-subtractor cell: d = x ^ y, borrow when x=0 and y=1.
module rb_half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

// Full-subtractor cell: two half-subtractors, borrows ORed together.
// b1 and b2 can never both be high, so OR is exact.
module rb_full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic d1, b1, b2;

  rb_half_sub u_hs0 (.x(x),  .y(y),  .d(d1), .b(b1));
  rb_half_sub u_hs1 (.x(d1), .y(bi), .d(d),  .b(b2));

  assign bo = b1 | b2;
endmodule

// Top: eight-cell ripple chain followed by the capture registers.
module rb_subtract_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bin,
  input  logic       in_valid,
  output logic       Bout,
  output logic [7:0] D,
  output logic       out_valid
);
  localparam int W = 8;

  // brw[i] is the borrow into bit i; brw[W] is the borrow out of bit W-1.
  logic [W:0]   brw;
  logic [W-1:0] diff;

  assign brw[0] = Bin;

  // One full-subtractor per bit; each cell's borrow-out feeds the next cell.
  rb_full_sub u_cell [W-1:0] (
    .x  (A),
    .y  (B),
    .bi (brw[W-1:0]),
    .d  (diff),
    .bo (brw[W:1])
  );

  logic [W-1:0] d_q, d_d;
  logic         bout_q, bout_d;
  logic         out_valid_q, out_valid_d;

  // Capture on accepted input; otherwise hold the result and drop valid.
  always_comb begin
    d_d         = d_q;
    bout_d      = bout_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      d_d         = diff;
      bout_d      = brw[W];
      out_valid_d = 1'b1;
    end
  end

  // Output registers; async reset clears everything, dropping any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      d_q         <= d_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign D         = d_q;
  assign Bout      = bout_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rb_subtract_8.sv
// Directed and exhaustive bench for rb_subtract_8.
module tb_rb_subtract_8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic       Bin, in_valid;
  logic       Bout;
  logic [7:0] D;
  logic       out_valid;

  int checks = 0;
  int failures = 0;

  rb_subtract_8 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Bin(Bin), .in_valid(in_valid),
    .Bout(Bout), .D(D), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Present one input, let it be captured, return #1 after that edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic vld);
    A = a; B = b; Bin = bin; in_valid = vld;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got D=%h Bout=%b ov=%b, want D=00 Bout=0 ov=0", D, Bout, out_valid);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got D=%h Bout=%b ov=%b, want D=00 Bout=0 ov=0", D, Bout, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [7] = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd36, 8'd200, 8'd255};
    logic [7:0] vb [7] = '{8'd0, 8'd1, 8'd1, 8'd5, 8'd12, 8'd128, 8'd199};
    logic [7:0] vd [7] = '{8'd0, 8'd0, 8'd1, 8'd3, 8'd24, 8'd72,  8'd56};
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], 1'b0, 1'b1);
      checks++;
      if (D !== vd[i] || Bout !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL basic_%0d: got D=%0d Bout=%b ov=%b, want D=%0d Bout=0 ov=1", i, D, Bout, out_valid, vd[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic [7:0] va [3] = '{8'd20, 8'd20, 8'd20};
    logic [7:0] vb [3] = '{8'd21, 8'd32, 8'd188};
    logic [7:0] vd [3] = '{8'hFF, 8'hF4, 8'h58};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b0, 1'b1);
      checks++;
      if (D !== vd[i] || Bout !== 1'b1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL negative_%0d: got D=%h Bout=%b ov=%b, want D=%h Bout=1 ov=1", i, D, Bout, out_valid, vd[i]);
      end
    end
  endtask

  task automatic test_borrow_in();
    logic [7:0] va [3] = '{8'h00, 8'h80, 8'h80};
    logic [7:0] vb [3] = '{8'h00, 8'h7F, 8'h80};
    logic [7:0] vd [3] = '{8'hFF, 8'h00, 8'hFF};
    logic       vo [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b1, 1'b1);
      checks++;
      if (D !== vd[i] || Bout !== vo[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL borrow_in_%0d: got D=%h Bout=%b ov=%b, want D=%h Bout=%b ov=1", i, D, Bout, out_valid, vd[i], vo[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    logic [7:0] va [3] = '{8'd5, 8'd0, 8'd250};
    logic [7:0] vb [3] = '{8'd9, 8'd1, 8'd3};
    drive(8'd36, 8'd12, 1'b0, 1'b1);
    checks++;
    if (D !== 8'd24 || Bout !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL gate_accept: got D=%0d Bout=%b ov=%b, want D=24 Bout=0 ov=1", D, Bout, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b1, 1'b0);
      checks++;
      if (D !== 8'd24 || Bout !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL gate_hold_%0d: got D=%0d Bout=%b ov=%b, want D=24 Bout=0 ov=0", i, D, Bout, out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(8'd200, 8'd128, 1'b0, 1'b1);
    checks++;
    if (D !== 8'd72 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: got D=%0d ov=%b, want D=72 ov=1", D, out_valid);
    end
    // Mid-cycle, away from any clock edge; keep offering valid data.
    #1;
    A = 8'd20; B = 8'd188; Bin = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: got D=%h Bout=%b ov=%b, want D=00 Bout=0 ov=0", D, Bout, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_discard: got D=%h Bout=%b ov=%b, want D=00 Bout=0 ov=0", D, Bout, out_valid);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (D !== 8'h00 || Bout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: got D=%h Bout=%b ov=%b, want D=00 Bout=0 ov=0", D, Bout, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [7:0] a, b;
    logic       bin;
    int         shown = 0;
    for (int i = 0; i < 65536; i++) begin
      a   = 8'(i >> 8);
      b   = 8'(i);
      bin = 1'($urandom_range(0, 1));
      exp = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      drive(a, b, bin, 1'b1);
      checks++;
      if (D !== exp[7:0] || Bout !== exp[8] || out_valid !== 1'b1) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL exhaustive a=%h b=%h bin=%b: got D=%h Bout=%b ov=%b, want D=%h Bout=%b ov=1",
                   a, b, bin, D, Bout, out_valid, exp[7:0], exp[8]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_borrow_in();
    test_valid_gating();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
